// File: rtl/ct_hpcp_evt_wr_ctrl.sv
// ct_hpcp_evt_wr_ctrl
//   Write sequencer for the HPM event-selector bank (mhpmevent3..mhpmevent31).
//   Serialises single CSR writes and a bulk clear into one register write per
//   cycle. Bulk clear has priority over a CSR write in the same cycle.
//
// Ports
//   eventx_clk   : block clock
//   cpurst_b     : asynchronous active-low reset
//   csr_wr_vld   : CSR write request (held by requester until accepted)
//   csr_wr_idx   : target CSR index, IDX_BASE..IDX_BASE+EVT_NUM-1 legal
//   csr_wr_data  : write data, passed through unmodified
//   csr_wr_rdy   : request accepted when csr_wr_vld & csr_wr_rdy
//   clr_req      : bulk-clear request, level sampled in IDLE
//   clr_done     : one-cycle pulse after the last register is cleared
//   evt_wen      : one-hot write enable, bit i = CSR index i+IDX_BASE
//   evt_clk_en   : per-register local clock enable, equals evt_wen
//   evt_wdata    : shared write data, zero whenever no enable is high
//   idx_err      : one-cycle pulse for an accepted write below IDX_BASE
//   ctrl_busy    : sequencer not idle
//   ctrl_clk_en  : keep-alive request for eventx_clk
module ct_hpcp_evt_wr_ctrl #(
    parameter int EVT_NUM   = 29,
    parameter int IDX_WIDTH = 5,
    parameter int IDX_BASE  = 3
) (
    input  logic                 eventx_clk,
    input  logic                 cpurst_b,
    input  logic                 csr_wr_vld,
    input  logic [IDX_WIDTH-1:0] csr_wr_idx,
    input  logic [63:0]          csr_wr_data,
    output logic                 csr_wr_rdy,
    input  logic                 clr_req,
    output logic                 clr_done,
    output logic [EVT_NUM-1:0]   evt_wen,
    output logic [EVT_NUM-1:0]   evt_clk_en,
    output logic [63:0]          evt_wdata,
    output logic                 idx_err,
    output logic                 ctrl_busy,
    output logic                 ctrl_clk_en
);

    localparam int CNT_W = (EVT_NUM > 1) ? $clog2(EVT_NUM) : 1;
    localparam logic [EVT_NUM-1:0]   WEN_LSB  = EVT_NUM'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(EVT_NUM - 1);
    localparam logic [IDX_WIDTH-1:0] BASE     = IDX_WIDTH'(IDX_BASE);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_WIDTH-1:0] wr_off;
    logic                 idx_low;
    logic                 idx_legal;

    assign cnt_nxt   = cnt + CNT_W'(1);
    assign wr_off    = csr_wr_idx - BASE;
    assign idx_low   = (csr_wr_idx < BASE);
    assign idx_legal = !idx_low && (32'(wr_off) < EVT_NUM);

    assign csr_wr_rdy  = (state == IDLE) && !clr_req;
    assign ctrl_busy   = (state != IDLE);
    assign ctrl_clk_en = ctrl_busy | csr_wr_vld | clr_req;
    assign evt_clk_en  = evt_wen;

    // The output registers are loaded on the edge that enters a state, so the
    // enable for a write (or for clear slot cnt) is visible during the cycle
    // the FSM spends in WRITE (or CLEAR with that cnt value).
    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            evt_wen   <= '0;
            evt_wdata <= '0;
            clr_done  <= 1'b0;
            idx_err   <= 1'b0;
        end else begin
            evt_wen   <= '0;
            evt_wdata <= '0;
            clr_done  <= 1'b0;
            idx_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        evt_wen <= WEN_LSB;
                    end else if (csr_wr_vld) begin
                        state   <= WRITE;
                        idx_err <= idx_low;
                        if (idx_legal) begin
                            evt_wen   <= WEN_LSB << wr_off;
                            evt_wdata <= csr_wr_data;
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                CLEAR: begin
                    if (cnt == CNT_LAST) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end else begin
                        cnt     <= cnt_nxt;
                        evt_wen <= WEN_LSB << cnt_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_hpcp_evt_wr_ctrl.sv
// Directed testbench for ct_hpcp_evt_wr_ctrl.
module tb_ct_hpcp_evt_wr_ctrl;

    localparam int EVT_NUM   = 29;
    localparam int IDX_WIDTH = 5;

    logic                 eventx_clk = 1'b0;
    logic                 cpurst_b   = 1'b0;
    logic                 csr_wr_vld = 1'b0;
    logic [IDX_WIDTH-1:0] csr_wr_idx = '0;
    logic [63:0]          csr_wr_data = '0;
    logic                 csr_wr_rdy;
    logic                 clr_req = 1'b0;
    logic                 clr_done;
    logic [EVT_NUM-1:0]   evt_wen;
    logic [EVT_NUM-1:0]   evt_clk_en;
    logic [63:0]          evt_wdata;
    logic                 idx_err;
    logic                 ctrl_busy;
    logic                 ctrl_clk_en;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    ct_hpcp_evt_wr_ctrl #(
        .EVT_NUM  (EVT_NUM),
        .IDX_WIDTH(IDX_WIDTH),
        .IDX_BASE (3)
    ) dut (
        .eventx_clk (eventx_clk),
        .cpurst_b   (cpurst_b),
        .csr_wr_vld (csr_wr_vld),
        .csr_wr_idx (csr_wr_idx),
        .csr_wr_data(csr_wr_data),
        .csr_wr_rdy (csr_wr_rdy),
        .clr_req    (clr_req),
        .clr_done   (clr_done),
        .evt_wen    (evt_wen),
        .evt_clk_en (evt_clk_en),
        .evt_wdata  (evt_wdata),
        .idx_err    (idx_err),
        .ctrl_busy  (ctrl_busy),
        .ctrl_clk_en(ctrl_clk_en)
    );

    always #5 eventx_clk = ~eventx_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] bit_at(input int unsigned i);
        logic [63:0] one;
        one = 64'd1;
        return one << i;
    endfunction

    // Invariants sampled every falling edge.
    always @(negedge eventx_clk) begin
        if (mon_en) begin
            chk("clk_en_eq_wen", 64'(evt_clk_en), 64'(evt_wen));
            chk("wen_onehot0", 64'($onehot0(evt_wen)), 64'd1);
            chk("clk_keepalive", 64'(ctrl_clk_en), 64'(ctrl_busy | csr_wr_vld | clr_req));
            if (evt_wen == '0)
                chk("wdata_idle_zero", evt_wdata, 64'd0);
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_wen"}, 64'(evt_wen), 64'd0);
        chk({tag, "_wdata"}, evt_wdata, 64'd0);
        chk({tag, "_done"}, 64'(clr_done), 64'd0);
        chk({tag, "_err"}, 64'(idx_err), 64'd0);
        chk({tag, "_busy"}, 64'(ctrl_busy), 64'd0);
        chk({tag, "_rdy"}, 64'(csr_wr_rdy), 64'd1);
    endtask

    // Single accepted write; outputs checked the cycle after acceptance and
    // the cycle after that.
    task automatic do_write(input logic [4:0] idx, input logic [63:0] data,
                            input logic [63:0] exp_wen, input logic exp_err);
        csr_wr_vld  = 1'b1;
        csr_wr_idx  = idx;
        csr_wr_data = data;
        #1;
        chk("wr_rdy_pre", 64'(csr_wr_rdy), 64'd1);
        @(negedge eventx_clk);
        csr_wr_vld = 1'b0;
        chk("wr_wen", 64'(evt_wen), exp_wen);
        chk("wr_wdata", evt_wdata, (exp_wen != 0) ? data : 64'd0);
        chk("wr_err", 64'(idx_err), 64'(exp_err));
        chk("wr_busy", 64'(ctrl_busy), 64'd1);
        chk("wr_rdy_busy", 64'(csr_wr_rdy), 64'd0);
        @(negedge eventx_clk);
        check_idle("wr_after");
    endtask

    initial begin
        // Reset held
        repeat (3) @(negedge eventx_clk);
        chk("rst_wen", 64'(evt_wen), 64'd0);
        chk("rst_busy", 64'(ctrl_busy), 64'd0);
        cpurst_b = 1'b1;
        mon_en   = 1'b1;
        @(negedge eventx_clk);
        check_idle("post_rst");
        chk("post_rst_clk_en", 64'(ctrl_clk_en), 64'd0);

        // Directed writes
        do_write(5'd5,  64'h0000_0000_0000_0011, bit_at(2), 1'b0);
        do_write(5'd31, 64'hDEAD_BEEF_0123_4567, bit_at(28), 1'b0);
        do_write(5'd3,  64'hFFFF_FFFF_FFFF_FFFF, bit_at(0), 1'b0);
        do_write(5'd17, 64'h0000_0000_0000_00A5, bit_at(14), 1'b0);
        do_write(5'd2,  64'h0000_0000_0000_1234, 64'd0, 1'b1);
        do_write(5'd0,  64'h0000_0000_0000_5678, 64'd0, 1'b1);

        // Bulk clear; clr_req held for a few cycles must not restart it
        clr_req = 1'b1;
        #1;
        chk("clr_rdy_low", 64'(csr_wr_rdy), 64'd0);
        for (int i = 0; i < EVT_NUM; i++) begin
            @(negedge eventx_clk);
            if (i == 3) clr_req = 1'b0;
            chk("clr_wen", 64'(evt_wen), bit_at(i));
            chk("clr_wdata", evt_wdata, 64'd0);
            chk("clr_busy", 64'(ctrl_busy), 64'd1);
            chk("clr_done_early", 64'(clr_done), 64'd0);
        end
        @(negedge eventx_clk);
        chk("clr_done", 64'(clr_done), 64'd1);
        chk("clr_done_wen", 64'(evt_wen), 64'd0);
        chk("clr_done_busy", 64'(ctrl_busy), 64'd1);
        @(negedge eventx_clk);
        check_idle("clr_after");

        // Clear and write together: clear wins, write stalls until after DONE
        clr_req     = 1'b1;
        csr_wr_vld  = 1'b1;
        csr_wr_idx  = 5'd31;
        csr_wr_data = 64'h0BAD_CAFE_0000_0031;
        #1;
        chk("both_rdy", 64'(csr_wr_rdy), 64'd0);
        @(negedge eventx_clk);
        clr_req = 1'b0;
        for (int i = 0; i < EVT_NUM; i++) begin
            if (i != 0) @(negedge eventx_clk);
            chk("both_clr_wen", 64'(evt_wen), bit_at(i));
            chk("both_rdy_stall", 64'(csr_wr_rdy), 64'd0);
        end
        @(negedge eventx_clk);
        chk("both_done", 64'(clr_done), 64'd1);
        chk("both_done_rdy", 64'(csr_wr_rdy), 64'd0);
        @(negedge eventx_clk);
        chk("both_idle_rdy", 64'(csr_wr_rdy), 64'd1);
        chk("both_idle_wen", 64'(evt_wen), 64'd0);
        @(negedge eventx_clk);
        csr_wr_vld = 1'b0;
        chk("both_wr_wen", 64'(evt_wen), bit_at(28));
        chk("both_wr_wdata", evt_wdata, 64'h0BAD_CAFE_0000_0031);
        @(negedge eventx_clk);
        check_idle("both_after");

        // Reset during clear at cnt == 10
        clr_req = 1'b1;
        @(negedge eventx_clk);
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge eventx_clk);
        chk("rstclr_wen10", 64'(evt_wen), bit_at(10));
        cpurst_b = 1'b0;
        #1;
        chk("rstclr_wen0", 64'(evt_wen), 64'd0);
        chk("rstclr_busy0", 64'(ctrl_busy), 64'd0);
        chk("rstclr_wdata0", evt_wdata, 64'd0);
        repeat (2) @(negedge eventx_clk);
        cpurst_b = 1'b1;
        for (int i = 0; i < EVT_NUM + 3; i++) begin
            @(negedge eventx_clk);
            chk("rstclr_no_done", 64'(clr_done), 64'd0);
            chk("rstclr_no_wen", 64'(evt_wen), 64'd0);
        end
        check_idle("rstclr_after");

        // Pipeline still works after the abandoned clear
        do_write(5'd4, 64'h0000_0000_0000_0044, bit_at(1), 1'b0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ct_hpcp_evt_wr_ctrl.md
Name: ct_hpcp_evt_wr_ctrl

Overview:
Write sequencer for the bank of HPM event-selector registers (mhpmevent3..mhpmevent31).
- Accepts single CSR write requests and a bulk-clear request.
- Arbitrates between them and drives, one register per cycle, the per-register write enable, local clock enable and shared write data consumed by the event-selector registers.
- Sits between the CP0 CSR write path and the event-selector bank inside the HPCP.

Parameters:
EVT_NUM, 29, number of event-selector registers (CSR index 3..31)
IDX_WIDTH, 5, width of CSR counter index
IDX_BASE, 3, CSR index mapped to evt_wen[0]

Ports:
eventx_clk  input  1  block clock
cpurst_b  input  1  reset
csr_wr_vld  input  1  CSR write request
csr_wr_idx  input  IDX_WIDTH  target CSR index (3..31 legal)
csr_wr_data  input  64  write data; passed unmodified (legality masking is done in each register)
csr_wr_rdy  output  1  request accepted this cycle when csr_wr_vld & csr_wr_rdy
clr_req  input  1  bulk-clear request (level-sampled)
clr_done  output  1  one-cycle pulse: bulk clear finished
evt_wen  output  EVT_NUM  one-hot write enable, bit i = CSR index i+IDX_BASE
evt_clk_en  output  EVT_NUM  local clock enable to each register's gated cell; equals evt_wen
evt_wdata  output  64  shared write data
idx_err  output  1  one-cycle pulse: accepted write had index < IDX_BASE
ctrl_busy  output  1  state != IDLE
ctrl_clk_en  output  1  keep-alive request for eventx_clk = ctrl_busy | csr_wr_vld | clr_req (combinational)

Behaviour:
Interface (already decided): reset cpurst_b, asynchronous, active-low; clock eventx_clk.

Reset:
- State IDLE, clear counter 0.
- evt_wen, evt_wdata, clr_done, idx_err all 0; ctrl_busy 0.

FSM states: IDLE, WRITE, CLEAR, DONE.
- IDLE:
  - clr_req=1 -> CLEAR with cnt=0. Clear has priority over a simultaneous CSR write, so csr_wr_rdy=0 that cycle.
  - Else csr_wr_vld=1 -> accept, register idx/data, go to WRITE.
- csr_wr_rdy = (state==IDLE) & !clr_req.
- WRITE (1 cycle):
  - If idx is legal: evt_wen[idx-IDX_BASE]=1 and evt_wdata=data.
  - If idx < IDX_BASE: evt_wen all 0 and idx_err=1.
  - Next state IDLE.
- CLEAR:
  - Each cycle evt_wen[cnt]=1, evt_wdata=0, cnt++.
  - When cnt==EVT_NUM-1, next state DONE. cnt never wraps past EVT_NUM-1.
- DONE (1 cycle): clr_done=1, next IDLE.

Output rules:
- Outputs are registered.
- At most one evt_wen bit is high per cycle.
- evt_wdata is 0 whenever no wen is asserted.

Latency:
- CSR write accepted in cycle N -> evt_wen in N+1 -> csr_wr_rdy again in N+2. Throughput is 1 write per 2 cycles.
- Clear accepted in N -> evt_wen[0] in N+1 ... evt_wen[EVT_NUM-1] in N+EVT_NUM -> clr_done in N+EVT_NUM+1 -> IDLE in N+EVT_NUM+2.

Boundary conditions:
- clr_req during WRITE/CLEAR/DONE: ignored. If still high on return to IDLE, a new clear starts.
- csr_wr_vld during a non-IDLE state: stalled, not dropped; requester holds vld/idx/data.
- csr_wr_vld in the same IDLE cycle as clr_req: CSR write waits until after DONE.
- Reset asserted mid-CLEAR: sequence abandoned, no clr_done, remaining registers not written.
- idx = IDX_BASE+EVT_NUM-1 (31): maps to the top bit. Index 0..2: error path, no write.

Test Plan:
- Reset release, idle inputs -> all outputs 0, csr_wr_rdy=1, ctrl_clk_en=0.
- csr_wr_vld, idx=5, data=0x0000_0000_0000_0011 in cycle N -> cycle N+1: evt_wen=1<<2, evt_wdata=0x11; N+2: evt_wen=0, rdy=1.
- clr_req pulse in cycle N -> evt_wen bits 0..28 one per cycle, N+1..N+29 with wdata 0; clr_done at N+30; ctrl_busy high N+1..N+30.
- clr_req and csr_wr_vld (idx=31) asserted together, vld held -> clear runs first, rdy=0 throughout. Write accepted at N+31, evt_wen[28] at N+32.
- Write with idx=2 -> idx_err pulse in the following cycle, evt_wen stays 0, FSM back to IDLE.
- cpurst_b asserted when cnt=10 during clear -> outputs 0 immediately; after release no clr_done, state IDLE, rdy=1.
